tag_lookup: RTL

Read side of the way-halting tag array. Accepts a lookup request (4-bit halt tag + 20-bit main tag), filters ways by halt-tag match in stage 1, then performs full main-tag compare only on surviving ways in stage 2. Returns hit, hit way and halt mask through a valid/ready handshake. Sits between the cache controller's address decode and the halt_tag/main_tag storage outputs.

---
 rtl/tag_lookup.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/tag_lookup.sv
// Way-halting tag array, read side.
// Stage 1 filters the ways by halt tag. Stage 2 does the full main-tag compare, but only on
// the ways that survived stage 1. Results return through a valid/ready handshake, and a
// response cannot be reordered or dropped.
// Optional feature: define TAG_LOOKUP_STATS_EN to add saturating hit/miss counters.
module tag_lookup #(
  parameter int unsigned WAYS     = 4,
  parameter int unsigned HALT_W   = 4,
  parameter int unsigned MAIN_W   = 20,
  parameter int unsigned WAY_BITS = $clog2(WAYS)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [HALT_W-1:0]        req_halt_tag_i,
  input  logic [MAIN_W-1:0]        req_main_tag_i,
  input  logic [WAYS*HALT_W-1:0]   way_halt_tag_i,
  input  logic [WAYS*MAIN_W-1:0]   way_main_tag_i,
  input  logic [WAYS-1:0]          way_valid_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic                     rsp_hit_o,
  output logic [WAY_BITS-1:0]      rsp_way_o,
  output logic                     rsp_multi_hit_o,
  output logic [WAYS-1:0]          rsp_halt_mask_o
`ifdef TAG_LOOKUP_STATS_EN
  ,
  output logic [15:0]              stat_hits_o,
  output logic [15:0]              stat_misses_o
`endif
);

  // Stage 1 registers
  logic              s1_valid_q;
  logic [MAIN_W-1:0] s1_main_q;
  logic [WAYS-1:0]   s1_halt_q;

  // Stage 2 registers
  logic                s2_valid_q;
  logic                s2_hit_q;
  logic                s2_multi_q;
  logic [WAY_BITS-1:0] s2_way_q;
  logic [WAYS-1:0]     s2_halt_q;

  logic                halt_mask_d;
  logic [WAYS-1:0]     halt_mask_vec_d;
  logic [WAYS-1:0]     match_d;
  logic [WAY_BITS-1:0] way_d;
  logic [WAY_BITS:0]   match_cnt;
  logic                s2_free, s1_adv, req_acc, rsp_fire;

  assign s2_free     = !s2_valid_q || rsp_ready_i;
  assign s1_adv      = s1_valid_q && s2_free;
  assign req_ready_o = !s1_valid_q || s2_free;
  assign req_acc     = req_valid_i && req_ready_o;
  assign rsp_fire    = s2_valid_q && rsp_ready_i;
  assign halt_mask_d = |halt_mask_vec_d;

  // Stage-1 filter: a valid way whose halt tag matches the request
  always_comb begin
    halt_mask_vec_d = '0;
    for (int i = 0; i < int'(WAYS); i++) begin
      halt_mask_vec_d[i] = way_valid_i[i] &&
                           (way_halt_tag_i[i*HALT_W +: HALT_W] == req_halt_tag_i);
    end
  end

  // Stage-2 compare on the surviving ways, then encode the lowest match and count the matches
  always_comb begin
    match_d   = '0;
    way_d     = '0;
    match_cnt = '0;
    for (int i = 0; i < int'(WAYS); i++) begin
      match_d[i] = s1_halt_q[i] && (way_main_tag_i[i*MAIN_W +: MAIN_W] == s1_main_q);
      match_cnt  = match_cnt + {{WAY_BITS{1'b0}}, match_d[i]};
    end
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (match_d[i]) way_d = WAY_BITS'(i);
    end
  end

  // Stage 1 loads on accept and empties when it advances into stage 2
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid_q <= 1'b0;
      s1_main_q  <= '0;
      s1_halt_q  <= '0;
    end else if (req_acc) begin
      s1_valid_q <= 1'b1;
      s1_main_q  <= req_main_tag_i;
      s1_halt_q  <= halt_mask_vec_d;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2 reloads on advance, which allows a consume and a reload on the same edge,
  // and clears once it has been consumed
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s2_valid_q <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_multi_q <= 1'b0;
      s2_way_q   <= '0;
      s2_halt_q  <= '0;
    end else if (s1_adv) begin
      s2_valid_q <= 1'b1;
      s2_hit_q   <= |match_d;
      s2_multi_q <= (match_cnt > 1);
      s2_way_q   <= way_d;
      s2_halt_q  <= s1_halt_q;
    end else if (rsp_fire) begin
      s2_valid_q <= 1'b0;
    end
  end

  assign rsp_valid_o     = s2_valid_q;
  assign rsp_hit_o       = s2_hit_q;
  assign rsp_way_o       = s2_way_q;
  assign rsp_multi_hit_o = s2_multi_q;
  assign rsp_halt_mask_o = s2_halt_q;

`ifdef TAG_LOOKUP_STATS_EN
  logic [15:0] stat_hits_q, stat_misses_q;

  // Saturating counters of consumed hits and misses
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else if (rsp_fire) begin
      if (s2_hit_q && stat_hits_q != 16'hFFFF) stat_hits_q <= stat_hits_q + 16'd1;
      if (!s2_hit_q && stat_misses_q != 16'hFFFF) stat_misses_q <= stat_misses_q + 16'd1;
    end
  end

  assign stat_hits_o   = stat_hits_q;
  assign stat_misses_o = stat_misses_q;
`endif

  // Unused unless a design needs a single any-halt-match flag
  logic unused_halt_any;
  assign unused_halt_any = halt_mask_d;

endmodule
